// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: two-stage valid/ready decoder from packed posit to sign/zero/inf/exponent/fraction
module posit_decode_pipe #(
    parameter int WIDTH = 8,
    parameter int ES = 1,
    localparam int FRACTION_BITS = WIDTH - 3 - ES,
    localparam int REGIME_BITS = $clog2(2 * (WIDTH - 2) + 1),
    localparam int EXPONENT_BITS = REGIME_BITS + ES
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sign,
    output logic                     out_is_zero,
    output logic                     out_is_inf,
    output logic [EXPONENT_BITS-1:0] out_exponent,
    output logic [FRACTION_BITS-1:0] out_fraction
);
    logic s1Valid, s1Sign, s1Zero, s1Inf, s1Advance;
    logic [WIDTH-2:0] s1Mag, rest;
    logic [REGIME_BITS-1:0] regime;
    logic [EXPONENT_BITS-1:0] decExp;
    logic [FRACTION_BITS-1:0] decFrac;
    int runLen;
    assign s1Advance = s1Valid && (!out_valid || out_ready);
    assign in_ready = !s1Valid || s1Advance;
    // rest holds es then fraction bits MSB-aligned once the regime run and its terminator are shifted out
    always_comb begin
        runLen = 0;
        for (int i = WIDTH - 2; i >= 0; i--)
            if (s1Mag[i] == s1Mag[WIDTH-2] && runLen == WIDTH - 2 - i) runLen++;
        rest = s1Mag << (runLen + 1);
        regime = s1Mag[WIDTH-2] ? REGIME_BITS'(runLen + WIDTH - 3) : REGIME_BITS'(WIDTH - 2 - runLen);
        decExp = (s1Zero || s1Inf) ? '0
               : (EXPONENT_BITS'(regime) << ES) | EXPONENT_BITS'(rest >> (WIDTH - 1 - ES));
        decFrac = (s1Zero || s1Inf) ? '0 : FRACTION_BITS'(rest >> 2);
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            s1Valid <= 1'b0;
            s1Sign <= 1'b0;
            s1Zero <= 1'b0;
            s1Inf <= 1'b0;
            s1Mag <= '0;
            out_valid <= 1'b0;
            out_sign <= 1'b0;
            out_is_zero <= 1'b0;
            out_is_inf <= 1'b0;
            out_exponent <= '0;
            out_fraction <= '0;
        end else begin
            if (in_ready) begin
                s1Valid <= in_valid;
                s1Sign <= in_data[WIDTH-1];
                s1Zero <= in_data == '0;
                s1Inf <= in_data == {1'b1, {(WIDTH-1){1'b0}}};
                s1Mag <= in_data[WIDTH-1] ? (WIDTH-1)'(-in_data) : in_data[WIDTH-2:0];
            end
            if (s1Advance) begin
                out_valid <= 1'b1;
                out_sign <= s1Sign;
                out_is_zero <= s1Zero;
                out_is_inf <= s1Inf;
                out_exponent <= decExp;
                out_fraction <= decFrac;
            end else if (out_ready) out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb_posit_decode_pipe: directed, backpressure, random and exhaustive checks of the 8-bit posit decoder
module tb_posit_decode_pipe;
    logic clock = 1'b0;
    logic reset, in_valid, out_ready;
    logic [7:0] in_data;
    logic [2:0] inReady, outValid, outSign, outZero, outInf;
    logic [3:0] exp0;
    logic [4:0] frac0;
    logic [4:0] exp1;
    logic [3:0] frac1;
    logic [5:0] exp2;
    logic [2:0] frac2;
    logic [11:0] got0, got1, got2;
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    posit_decode_pipe #(.WIDTH(8), .ES(0)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(inReady[0]), .in_data(in_data),
        .out_valid(outValid[0]), .out_ready(out_ready), .out_sign(outSign[0]), .out_is_zero(outZero[0]),
        .out_is_inf(outInf[0]), .out_exponent(exp0), .out_fraction(frac0));
    posit_decode_pipe #(.WIDTH(8), .ES(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(inReady[1]), .in_data(in_data),
        .out_valid(outValid[1]), .out_ready(out_ready), .out_sign(outSign[1]), .out_is_zero(outZero[1]),
        .out_is_inf(outInf[1]), .out_exponent(exp1), .out_fraction(frac1));
    posit_decode_pipe #(.WIDTH(8), .ES(2)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(inReady[2]), .in_data(in_data),
        .out_valid(outValid[2]), .out_ready(out_ready), .out_sign(outSign[2]), .out_is_zero(outZero[2]),
        .out_is_inf(outInf[2]), .out_exponent(exp2), .out_fraction(frac2));

    assign got0 = {outSign[0], outZero[0], outInf[0], exp0, frac0};
    assign got1 = {outSign[1], outZero[1], outInf[1], exp1, frac1};
    assign got2 = {outSign[2], outZero[2], outInf[2], exp2, frac2};

    // Reference decode by walking a bit pointer through the magnitude; result {sign,zero,inf,exp,frac}
    function automatic logic [11:0] model(input int es, input logic [7:0] d);
        logic [7:0] mag;
        logic r;
        int p, m, k, eb, f;
        if (d == 8'h00 || d == 8'h80) return {d[7], d == 8'h00, d == 8'h80, 9'd0};
        mag = d[7] ? 8'(~d + 8'd1) : d;
        r = mag[6];
        p = 6;
        m = 0;
        while (p >= 0 && mag[p] == r) begin
            m++;
            p--;
        end
        k = r ? m - 1 : -m;
        p--;
        eb = 0;
        for (int j = 0; j < es; j++) begin
            eb = eb * 2 + ((p >= 0) ? int'(mag[p]) : 0);
            p--;
        end
        f = 0;
        for (int j = 0; j < 5 - es; j++) begin
            f = f * 2 + ((p >= 0) ? int'(mag[p]) : 0);
            p--;
        end
        return {d[7], 2'b00, 9'(((((k + 6) << es) + eb) << (5 - es)) | f)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d, output logic [11:0] got, output bit ok);
        in_valid = 1'b1;
        in_data = d;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        ok = 1'b0;
        got = '0;
        for (int c = 0; c < 10 && !ok; c++) begin
            if (outValid[1]) begin
                ok = 1'b1;
                got = got1;
            end else step();
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h40;
        out_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (outValid !== 3'b000 || inReady !== 3'b111) begin
            failures++;
            $display("FAIL reset_handshake valid=%b ready=%b expected valid=000 ready=111", outValid, inReady);
        end
        checks++;
        if (got1 !== 12'h000) begin
            failures++;
            $display("FAIL reset_data got=%h expected=000", got1);
        end
        reset = 1'b0;
        step();
        in_valid = 1'b0;
        checks++;
        if (outValid[1] !== 1'b0) begin
            failures++;
            $display("FAIL latency_early out_valid=%b expected=0", outValid[1]);
        end
        step();
        checks++;
        if (outValid[1] !== 1'b1 || got1 !== 12'b000_01100_0000) begin
            failures++;
            $display("FAIL latency_two valid=%b got=%h expected valid=1 data=%h", outValid[1], got1, 12'b000_01100_0000);
        end
        step();
        checks++;
        if (outValid[1] !== 1'b0) begin
            failures++;
            $display("FAIL single_output valid=%b expected=0", outValid[1]);
        end
    endtask

    task automatic test_directed();
        logic [7:0] dv[5] = '{8'h40, 8'h58, 8'hC0, 8'h01, 8'h7F};
        logic [11:0] ev[5] = '{12'b000_01100_0000, 12'b000_01101_1000, 12'b100_01100_0000,
                               12'b000_00000_0000, 12'b000_11000_0000};
        logic [11:0] got;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            push_one(dv[i], got, ok);
            checks++;
            if (!ok || got !== ev[i]) begin
                failures++;
                $display("FAIL directed_%h got=%h valid=%b expected=%h", dv[i], got, ok, ev[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [7:0] dv[2] = '{8'h00, 8'h80};
        logic [11:0] ev[2] = '{12'b010_00000_0000, 12'b101_00000_0000};
        logic [11:0] got;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            push_one(dv[i], got, ok);
            checks++;
            if (!ok || got !== ev[i]) begin
                failures++;
                $display("FAIL special_%h got=%h valid=%b expected=%h", dv[i], got, ok, ev[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h40;
        @(negedge clock);
        checks++;
        if (inReady[1] !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept1 in_ready=%b expected=1", inReady[1]);
        end
        step();
        in_data = 8'h50;
        @(negedge clock);
        checks++;
        if (inReady[1] !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept2 in_ready=%b expected=1", inReady[1]);
        end
        step();
        in_data = 8'h58;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (inReady[1] !== 1'b0 || outValid[1] !== 1'b1 || got1 !== 12'b000_01100_0000) begin
                failures++;
                $display("FAIL bp_hold_%0d ready=%b valid=%b got=%h expected ready=0 valid=1 data=%h",
                         i, inReady[1], outValid[1], got1, 12'b000_01100_0000);
            end
            if (i < 3) step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (inReady[1] !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_comb in_ready=%b expected=1", inReady[1]);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (outValid[1] !== 1'b1 || got1 !== 12'b000_01101_0000) begin
            failures++;
            $display("FAIL bp_drain_50 valid=%b got=%h expected=%h", outValid[1], got1, 12'b000_01101_0000);
        end
        step();
        checks++;
        if (outValid[1] !== 1'b1 || got1 !== 12'b000_01101_1000) begin
            failures++;
            $display("FAIL bp_drain_58 valid=%b got=%h expected=%h", outValid[1], got1, 12'b000_01101_1000);
        end
        step();
        checks++;
        if (outValid[1] !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_dup valid=%b expected=0", outValid[1]);
        end
    endtask

    task automatic test_midstream_reset();
        logic [11:0] got;
        bit ok;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h58;
        step();
        step();
        in_valid = 1'b0;
        checks++;
        if (outValid[1] !== 1'b1 || inReady[1] !== 1'b0) begin
            failures++;
            $display("FAIL mid_full valid=%b ready=%b expected valid=1 ready=0", outValid[1], inReady[1]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outValid !== 3'b000 || got1 !== 12'h000) begin
            failures++;
            $display("FAIL mid_async valid=%b got=%h expected valid=000 data=000", outValid, got1);
        end
        step();
        reset = 1'b0;
        push_one(8'h7F, got, ok);
        checks++;
        if (!ok || got !== 12'b000_11000_0000) begin
            failures++;
            $display("FAIL mid_after got=%h valid=%b expected=%h", got, ok, 12'b000_11000_0000);
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] d;
        int sent = 0;
        int nOut = 0;
        int cyc = 0;
        while (nOut < 1000 && cyc < 20000) begin
            in_valid = (sent < 1000) && ($urandom_range(3) != 0);
            in_data = 8'($urandom);
            out_ready = $urandom_range(2) != 0;
            @(negedge clock);
            if (in_valid && inReady[1]) begin
                q.push_back(in_data);
                sent++;
            end
            if (outValid[1] && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL random_extra got=%h expected no output", got1);
                end else begin
                    d = q.pop_front();
                    if (got1 !== model(1, d)) begin
                        failures++;
                        $display("FAIL random_%0d in=%h got=%h expected=%h", nOut, d, got1, model(1, d));
                    end
                end
                nOut++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (nOut != 1000 || q.size() != 0) begin
            failures++;
            $display("FAIL random_count outputs=%0d pending=%0d expected outputs=1000 pending=0", nOut, q.size());
        end
        step();
    endtask

    task automatic test_exhaustive();
        logic [7:0] d;
        int idx = 0;
        int nOut = 0;
        int cyc = 0;
        out_ready = 1'b1;
        while (nOut < 256 && cyc < 1000) begin
            in_valid = idx < 256;
            in_data = 8'(idx);
            @(negedge clock);
            if (outValid[1]) begin
                d = 8'(nOut);
                checks += 3;
                if (got0 !== model(0, d)) begin
                    failures++;
                    $display("FAIL exh_es0_%h got=%h expected=%h", d, got0, model(0, d));
                end
                if (got1 !== model(1, d)) begin
                    failures++;
                    $display("FAIL exh_es1_%h got=%h expected=%h", d, got1, model(1, d));
                end
                if (got2 !== model(2, d)) begin
                    failures++;
                    $display("FAIL exh_es2_%h got=%h expected=%h", d, got2, model(2, d));
                end
                nOut++;
            end
            if (in_valid && inReady[1]) idx++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (nOut != 256) begin
            failures++;
            $display("FAIL exh_count outputs=%0d expected=256", nOut);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        test_reset();
        test_directed();
        test_specials();
        test_backpressure();
        test_midstream_reset();
        test_random();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/posit_decode_pipe.md
Name: posit_decode_pipe

Overview:
Pipelined posit decoder. It converts a packed posit word into the unpacked (sign, isZero, isInf, biased exponent, fraction) form that the rounding and packing stages consume. This is the entry point of the posit datapath, the inverse of round-then-pack. It has a two-stage valid/ready pipeline with full backpressure.

Parameters:
WIDTH, 8, posit word width; legal range 3..32
ES, 1, posit exponent field width; legal range 0..(WIDTH-3)
FRACTION_BITS, WIDTH-3-ES, derived (localparam), max fraction bits
REGIME_BITS, $clog2(2*(WIDTH-2)+1), derived, unsigned regime width
EXPONENT_BITS, REGIME_BITS+ES, derived, unsigned exponent width

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high
in_valid  input  1  input word present
in_ready  output  1  block can accept the input word this cycle
in_data  input  WIDTH  packed posit
out_valid  output  1  decoded result present
out_ready  input  1  consumer accepts the result
out_sign  output  1  sign bit of the input
out_is_zero  output  1  input was all-zero
out_is_inf  output  1  input was 1 followed by all zeros (NaR/inf)
out_exponent  output  EXPONENT_BITS  {unsigned regime, es bits}
out_fraction  output  FRACTION_BITS  fraction, MSB-aligned, hidden bit excluded

Behaviour:
- Reset (async assert) clears both stage valid flags and all data registers. Outputs after reset: out_valid=0, all out_* data=0, in_ready=1.
- Transfer rules: an input is accepted when in_valid && in_ready. An output is consumed when out_valid && out_ready.
- Stage 1 register (s1) captures the input. Stage 2 register (s2) drives the out_* ports directly from flops.
- Advance logic:
  - s2 loads when s1 is valid and (s2 is empty or out_ready).
  - s1 loads when s1 is empty or s1 advances this cycle.
  - in_ready = !s1_valid || s1_advance. in_ready is combinational from out_ready; there is no combinational path from in_valid.
- Latency: accept in cycle N gives out_valid in cycle N+2 when there is no stall. Throughput is 1 per cycle with out_ready held high.
- When out_valid is set and out_ready is low, all out_* signals hold stable. No drop and no duplicate under any backpressure pattern.
- Stage 1 work:
  - Detect zero (in_data==0) and inf (in_data=={1,0...}).
  - Register sign.
  - Register the magnitude: the two's complement of in_data when the sign is 1, otherwise in_data.
- Stage 2 work, on magnitude bits [WIDTH-2:0]:
  - Regime: let r be bit WIDTH-2 and m the run length of bits equal to r, counting down from WIDTH-2 (1 ≤ m ≤ WIDTH-1).
  - k = m-1 if r=1, else -m.
  - unsigned regime = k + (WIDTH-2), range 0..2*(WIDTH-2).
  - Skip the run and the terminating bit, if one is present. The next ES bits are es; missing bits read as 0. The remaining bits, MSB-aligned, zero-filled, are the fraction.
  - out_exponent = {unsigned regime, es}.
- Special values: zero and inf force out_exponent=0 and out_fraction=0. out_sign is the raw input MSB, so inf reports sign=1.
- Reset asserted mid-stream: in-flight words are discarded and out_valid falls asynchronously. After reset deasserts, the first accepted word emerges after 2 cycles.
- Simultaneous accept and consume while full: both occur in the same cycle, and occupancy is unchanged.

Test Plan:
- Reset with in_valid=1 -> out_valid=0 and in_ready=1 during reset. After release, the first output appears 2 cycles after the accept.
- WIDTH=8/ES=1 directed values, out_ready=1:
  - 0x40 -> sign0, exp 12, frac 0
  - 0x58 -> exp 13, frac 4'b1000
  - 0xC0 -> sign1, exp 12, frac 0
  - 0x01 -> exp 0, frac 0
  - 0x7F -> exp 24, frac 0
- Specials: 0x00 -> is_zero=1, exp 0, frac 0. 0x80 -> is_inf=1, sign1, exp 0, frac 0.
- Backpressure: stream 0x40,0x50,0x58 with out_ready=0 -> in_ready drops after 2 accepts and out_* holds 0x40's decode. Raising out_ready -> outputs 12/13/13 appear in order with no gaps or duplicates.
- Random throughput: 1000 random words with random in_valid and out_ready -> output sequence matches the reference-model decode in order.
- Exhaustive WIDTH=8, ES=0 and ES=2 -> all 256 codes match the model.
